// File: rtl/kamacore_pkg.sv
// kamacore shared package: datapath widths, opcodes,
// fetch FSM states and the fetch-to-decode bundle.
package kamacore_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int RAM_SIZE   = 1 << ADDR_WIDTH;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic {
    FETCH_RUN,
    FETCH_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic                 valid;
    logic [CPU_WIDTH-1:0] instr;
    logic [CPU_WIDTH-1:0] pc;
  } if_id_t;

endpackage

// File: rtl/kamacore_fetch_pc.sv
// kamacore fetch program counter: redirect beats load.
// Ports: clk, rst_n, load, redirect, target -> pc.
module kamacore_fetch_pc
  import kamacore_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 redirect,
  input  logic [CPU_WIDTH-1:0] target,
  output logic [CPU_WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target;
    end else if (load) begin
      pc <= pc + CPU_WIDTH'(4);
    end
  end

endmodule

// File: rtl/kamacore_fetch.sv
// kamacore fetch stage: pc, imem read, valid/ready output reg.
// Ports: clk, rst_n, imem_addr/imem_data, redirect_valid/pc,
// out_valid/ready/instr/pc, out_fault.
// Macro KAMACORE_FETCH_MISALIGN_EN enables misaligned-redirect fault.
module kamacore_fetch
  import kamacore_pkg::*;
#(
  parameter int                   MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter logic [CPU_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [CPU_WIDTH-1:0]      imem_data,
  input  logic                      redirect_valid,
  input  logic [CPU_WIDTH-1:0]      redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CPU_WIDTH-1:0]      out_instr,
  output logic [CPU_WIDTH-1:0]      out_pc,
  output logic                      out_fault
);

  fetch_state_t         state;
  if_id_t               q;
  logic [CPU_WIDTH-1:0] pc;
  logic                 load;
  logic                 bad;
  logic                 fault_q;

  assign load = (state == FETCH_RUN) &&
                (!q.valid || out_ready);

`ifdef KAMACORE_FETCH_MISALIGN_EN
  assign bad = |redirect_pc[1:0];
`else
  assign bad = 1'b0;
`endif

  kamacore_fetch_pc #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .redirect(redirect_valid),
    .target  (redirect_pc),
    .pc      (pc)
  );

  // Byte offset bits never reach memory.
  assign imem_addr = pc[MEM_ADDR_WIDTH+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH_RUN;
      fault_q <= 1'b0;
      q       <= '0;
    end else if (redirect_valid) begin
      // Squash whatever is held, even if accepted now.
      q.valid <= 1'b0;
      state   <= bad ? FETCH_FAULT : FETCH_RUN;
      fault_q <= bad;
    end else if (load) begin
      q.valid <= 1'b1;
      q.instr <= imem_data;
      q.pc    <= pc;
    end else if (q.valid && out_ready) begin
      q.valid <= 1'b0;
    end
  end

  assign out_valid = q.valid;
  assign out_instr = q.instr;
  assign out_pc    = q.pc;
  assign out_fault = fault_q;

endmodule

// File: doc/kamacore_fetch.md
# kamacore_fetch

Instruction fetch stage for the kamacore CPU. It holds the program counter, presents a word address to the instruction memory's asynchronous dual-port read port, and registers the returned instruction with its PC into a valid/ready output register feeding decode. It accepts control-flow redirects from execute, and optionally traps misaligned redirect targets.

## Interface
Parameters:
- MEM_ADDR_WIDTH, default ADDR_WIDTH: width of the instruction-memory word address.
- RESET_PC, default 0: byte address fetched first after reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- imem_addr  out  MEM_ADDR_WIDTH  word address to the memory read port; equals pc[MEM_ADDR_WIDTH+1:2].
- imem_data  in  CPU_WIDTH  instruction word, combinationally valid in the same cycle as imem_addr.
- redirect_valid  in  1  one-cycle redirect request from execute.
- redirect_pc  in  CPU_WIDTH  byte-address redirect target.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  decode accepts the output this cycle.
- out_instr  out  CPU_WIDTH  registered instruction.
- out_pc  out  CPU_WIDTH  byte address of out_instr.
- out_fault  out  1  misaligned-redirect fault pending (see Configuration).

## Operation
- State: pc (CPU_WIDTH), output register {out_valid, out_instr, out_pc}, and FSM state in {RUN, FAULT}.
- load = (state == RUN) && (!out_valid || out_ready).
- Without redirect, on load: out_instr <= imem_data, out_pc <= pc, out_valid <= 1, pc <= pc + 4 (wraps modulo 2^CPU_WIDTH).
- Without redirect, if out_valid && out_ready && !load: out_valid <= 0.
- Otherwise the output register and pc hold.
- Redirect has priority over all other activity. When redirect_valid is high, out_valid <= 0 (any held or in-flight instruction is squashed, even if out_ready is high the same cycle), pc <= redirect_pc, and nothing is loaded that cycle.
- The low two bits of pc never reach imem_addr. Addresses above RAM_SIZE are not checked.
- FSM: RUN -> FAULT on a misaligned redirect (macro only). FAULT -> RUN on an aligned redirect. A misaligned redirect while already in FAULT stays in FAULT and updates pc.
- In FAULT, no loads occur, out_valid stays 0 and out_fault is 1.
- Memory writes landing on the fetched word at the same edge are not forwarded; the pre-edge contents are captured.

## Timing
- Reset values: pc = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0, out_fault = 0, state = RUN.
- Asynchronous assertion of rst_n clears everything immediately, including mid-stall or mid-redirect.
- First edge after deassertion loads RESET_PC. out_valid is 1 in the first cycle after that edge.
- Fetch-to-output latency is 1 cycle. Throughput is 1 instruction per cycle while out_ready is held high.
- Redirect in cycle N: out_valid = 0 in cycle N+1, and the target instruction is valid in cycle N+2 (1-cycle bubble).
- Backpressure: out_instr and out_pc are stable while out_valid && !out_ready.
- out_fault rises the cycle after the misaligned redirect and falls the cycle after the aligned redirect.

## Configuration
- Macro: KAMACORE_FETCH_MISALIGN_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 enters FAULT. pc still takes the full value.
- Undefined: no fault is detected, FAULT is unreachable, and out_fault is tied 0. A misaligned target fetches the word at redirect_pc[MEM_ADDR_WIDTH+1:2]; out_pc and pc keep the low bits, and subsequent PCs advance by 4 from there.

## Structure
- Shared package kamacore_pkg holds CPU_WIDTH, ADDR_WIDTH, opcode constants, and a new fetch_state_t enum {FETCH_RUN, FETCH_FAULT}.
- Sub-module kamacore_fetch_pc: the pc register with increment and redirect muxing. It exposes pc and takes load and redirect inputs.
- The top level owns the output register and FSM.

## Test plan
- Reset with RESET_PC=0, memory words 0..3 = 0x11,0x22,0x33,0x44, out_ready=1 -> out_instr 0x11,0x22,0x33,0x44 on consecutive cycles from cycle 1; out_pc 0,4,8,12.
- out_ready=0 for 3 cycles while holding 0x22 -> out_instr=0x22 and out_pc=4 stay stable, and imem_addr stays 2. After release, 0x33 follows next cycle.
- redirect_valid with redirect_pc=0x20 while out_valid=1 and out_ready=1 -> next cycle out_valid=0, the following cycle out_pc=0x20 with the word at address 8.
- Macro on, redirect_pc=0x22 -> out_fault=1 and out_valid=0 indefinitely. Then redirect_pc=0x40 -> out_fault=0 and out_pc=0x40 two cycles later.
- Macro off, redirect_pc=0x22 -> out_fault stays 0, out_pc=0x22 with the word at index 8, then 0x26.
- rst_n asserted mid-stream during a stall -> out_valid=0 immediately. After release, fetch restarts at RESET_PC.
